// File: rtl/ring_inject_arbiter_pkg.sv
// Shared types and constants for the ring injection arbiter.
package ring_inject_arbiter_pkg;

  localparam int unsigned ID_W     = 8;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned PKT_W    = 2 * ID_W + DATA_W;
  localparam int unsigned STARVE_W = 8;

  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

  // Packet layout, src in the MSBs.
  typedef struct packed {
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   dest;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic [0:0] {
    StNormal,
    StForce
  } arb_state_t;

  // Saturating increment for the starvation counter.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] v);
    return (v == STARVE_MAX) ? v : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/ring_inject_arbiter_credit_counter.sv
// Downstream credit tracker: one credit per free slot in the next node's buffer.
module ring_inject_arbiter_credit_counter #(
  parameter int unsigned CREDITS = 8,
  localparam int unsigned CNT_W  = $clog2(CREDITS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             consume,
  input  logic             credit_in,
  output logic [CNT_W-1:0] count,
  output logic             can_send,
  output logic             overflow_err
);
  import ring_inject_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  // Next credit count; a simultaneous consume and return cancel out.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (consume && !credit_in) begin
      count_d = count_q - CNT_W'(1);
    end else if (credit_in && !consume) begin
      if (count_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Credit and sticky overflow state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= FULL;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // A credit returned this cycle is only usable from the next cycle on.
  assign can_send     = (count_q != '0);
  assign count        = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: rtl/ring_inject_arbiter.sv
// Ring node traffic controller: ejects local-bound packets, arbitrates the
// forward slot between through-traffic and local injection, tracks credits.
module ring_inject_arbiter #(
  parameter int unsigned ID_W         = ring_inject_arbiter_pkg::ID_W,
  parameter int unsigned DATA_W       = ring_inject_arbiter_pkg::DATA_W,
  parameter int unsigned PKT_W        = 2 * ID_W + DATA_W,
  parameter int unsigned NODE_ID      = 0,
  parameter int unsigned CREDITS      = 8,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned CNT_W       = $clog2(CREDITS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid,
  input  logic [PKT_W-1:0] up_pkt,
  output logic             up_ready,
  input  logic             loc_valid,
  input  logic [PKT_W-1:0] loc_pkt,
  output logic             loc_ready,
  output logic             eject_valid,
  output logic [PKT_W-1:0] eject_pkt,
  input  logic             eject_ready,
  output logic             out_valid,
  output logic [PKT_W-1:0] out_pkt,
  input  logic             credit_in,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             forced,
  output logic             err_self,
  output logic             err_credit
);
  import ring_inject_arbiter_pkg::*;

  localparam logic [ID_W-1:0]     MY_ID = ID_W'(NODE_ID);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [ID_W-1:0] up_dest, loc_dest;
  logic            up_eject, up_fwd, loc_self, loc_req;
  logic            can_send, grant_up, grant_loc, grant;

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic             out_valid_q;
  logic [PKT_W-1:0] out_pkt_q;
  logic             err_self_q;

  assign up_dest  = up_pkt[DATA_W +: ID_W];
  assign loc_dest = loc_pkt[DATA_W +: ID_W];

  assign up_eject = up_valid && (up_dest == MY_ID);
  assign up_fwd   = up_valid && !up_eject;
  // Self-addressed local packets are swallowed, never competing for the slot.
  assign loc_self = loc_valid && (loc_dest == MY_ID);
  assign loc_req  = loc_valid && !loc_self;

  // Slot arbitration, starvation tracking and FORCE entry/exit.
  always_comb begin
    grant_up  = 1'b0;
    grant_loc = 1'b0;
    state_d   = state_q;
    starve_d  = starve_q;

    unique case (state_q)
      StNormal: begin
        grant_up  = can_send && up_fwd;
        grant_loc = can_send && loc_req && !grant_up;
      end
      StForce: begin
        grant_loc = can_send && loc_req;
      end
      default: begin
        grant_up  = 1'b0;
        grant_loc = 1'b0;
      end
    endcase

    if (!loc_req || grant_loc) begin
      starve_d = '0;
    end else begin
      starve_d = starve_inc(starve_q);
    end

    unique case (state_q)
      StNormal: begin
        if (starve_d >= LIMIT) begin
          state_d = StForce;
        end
      end
      StForce: begin
        if (grant_loc || !loc_req) begin
          state_d = StNormal;
        end
      end
      default: begin
        state_d = StNormal;
      end
    endcase
  end

  assign grant = grant_up || grant_loc;

  // Arbiter state and starvation counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StNormal;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Registered forward stage; packet holds when there is no grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      err_self_q  <= 1'b0;
    end else begin
      out_valid_q <= grant;
      err_self_q  <= loc_self;
      if (grant) begin
        out_pkt_q <= grant_up ? up_pkt : loc_pkt;
      end
    end
  end

  ring_inject_arbiter_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clock        (clock),
    .reset        (reset),
    .consume      (grant),
    .credit_in    (credit_in),
    .count        (credit_cnt),
    .can_send     (can_send),
    .overflow_err (err_credit)
  );

  // Ejection bypasses the slot and credits entirely.
  assign up_ready    = up_eject ? eject_ready : grant_up;
  assign loc_ready   = loc_self || grant_loc;
  assign eject_valid = up_eject;
  assign eject_pkt   = up_pkt;
  assign out_valid   = out_valid_q;
  assign out_pkt     = out_pkt_q;
  assign forced      = (state_q == StForce);
  assign err_self    = err_self_q;

endmodule

// File: doc/ring_inject_arbiter.md
Name: ring_inject_arbiter

Overview:
Per-node traffic controller placed between a ring node's upstream link and its downstream link. Each cycle it decides three things:
- whether the packet arriving from upstream is ejected to the local core or forwarded;
- whether upstream through-traffic or a local core injection gets the single forward slot;
- whether the downstream buffer has space for the forwarded packet, tracked with credits.

Through-traffic has priority. A starvation counter forces local injection after a bounded wait.

Parameters:
- ID_W, 8, width of src/dest fields
- DATA_W, 128, payload width
- PKT_W, 2*ID_W+DATA_W (144), packet width; layout {src, dest, data}, src in the MSBs
- NODE_ID, 0, this node's ring address
- CREDITS, 8, downstream buffer depth; initial credit count
- STARVE_LIMIT, 4, consecutive lost cycles before local is forced (1..255)

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- up_valid  in  1  upstream packet present
- up_pkt  in  PKT_W  upstream packet
- up_ready  out  1  upstream packet consumed this cycle (combinational)
- loc_valid  in  1  local core injection request
- loc_pkt  in  PKT_W  local packet
- loc_ready  out  1  local packet consumed this cycle (combinational)
- eject_valid  out  1  upstream packet addressed to NODE_ID (combinational)
- eject_pkt  out  PKT_W  equals up_pkt
- eject_ready  in  1  core accepts the ejected packet
- out_valid  out  1  registered forward strobe to downstream
- out_pkt  out  PKT_W  registered forward packet
- credit_in  in  1  downstream freed one slot
- credit_cnt  out  $clog2(CREDITS+1)  current credit count
- forced  out  1  arbiter is in the FORCE state
- err_self  out  1  one-cycle pulse: local packet addressed to NODE_ID was dropped
- err_credit  out  1  sticky: credit_in arrived while credit_cnt == CREDITS

Behaviour:
Reset values:
- out_valid=0, out_pkt=0, credit_cnt=CREDITS, state=NORMAL, starve counter=0, err_credit=0, err_self=0.
- Reset asserted mid-operation discards the registered output and all counters immediately.

Ejection (combinational):
- up_eject = up_valid && up_pkt.dest==NODE_ID.
- eject_valid=up_eject.
- When up_eject, up_ready=eject_ready. Ejected packets never consume credits or the forward slot.

Forward slot:
- up_fwd = up_valid && !up_eject.
- can_send = credit_cnt>0. A credit_in arriving in the same cycle does not count toward can_send.
- Local packets with dest==NODE_ID: loc_ready=1, err_self pulses, no forward, no credit, starve counter cleared.

NORMAL state:
- If can_send && up_fwd: grant upstream (up_ready=1).
- Otherwise, if can_send && loc_valid: grant local.
- Starve counter increments each cycle loc_valid is high (non-self) and local is not granted, saturating at 255. It clears when local is granted or loc_valid is low.
- When the counter reaches STARVE_LIMIT, go to FORCE on the next edge.

FORCE state:
- up_fwd is not granted (up_ready=0 unless ejecting).
- Local is granted the first cycle can_send && loc_valid holds; then go to NORMAL and clear the counter.
- If loc_valid drops while in FORCE, go to NORMAL.

Grant effects:
- A grant registers out_valid=1 and out_pkt=the granted packet on the next edge: latency 1 cycle.
- Without a grant, out_valid=0 and out_pkt holds its last value.

Credits:
- grant && !credit_in: decrement.
- credit_in && !grant: increment.
- Both together: unchanged.
- credit_in while credit_cnt==CREDITS and no grant: count stays at CREDITS and err_credit is set until reset.

Simultaneous events: upstream ejection and a local grant can both occur in the same cycle.

Decomposition:
- Shared package (NetworkPkg): pkt_t typedef {src, dest, data}, ID_W/DATA_W constants, and an arb_state_t enum {NORMAL, FORCE}.
- One natural sub-module: credit_counter (parameter CREDITS; ports consume, credit_in, count, can_send, overflow_err).

Test Plan:
1. Reset, then up_valid=1, up_pkt dest=2, NODE_ID=0 → up_ready=1 the same cycle; next cycle out_valid=1, out_pkt=up_pkt; credit_cnt 8→7.
2. up_pkt dest=0 with eject_ready=0 → eject_valid=1, up_ready=0, out_valid stays 0; raise eject_ready → up_ready=1, credit_cnt unchanged.
3. Continuous up_fwd plus loc_valid (STARVE_LIMIT=4) → upstream granted 4 cycles; forced=1 in cycle 5; local granted in cycle 5 with up_ready=0; out_pkt=loc_pkt in cycle 6; forced=0 afterwards.
4. Nine back-to-back forwards with no credit_in → 8 grants; credit_cnt=0; up_ready=0 in cycle 9; one credit_in → next cycle grant resumes, credit_cnt stays 0 after the grant.
5. Grant and credit_in in the same cycle at credit_cnt=5 → credit_cnt stays 5. credit_in with credit_cnt=8 and no grant → err_credit=1, credit_cnt=8.
6. Local packet dest=0 → loc_ready=1, err_self pulses 1 cycle, out_valid=0. Assert reset during FORCE with out_valid=1 → out_valid=0, forced=0, credit_cnt=8 immediately.
